// File: rtl/ipif_request_arbiter.sv
// Round-robin arbiter that lets N_REQ internal masters share a single IPIF
// register-bank port. Each granted transaction is one word: decode, one CE
// pulse, wait for the matching ack (or time out), then a one-hot response.
module ipif_request_arbiter #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int N_REG              = 2,
    parameter int N_REQ              = 4,
    parameter int TIMEOUT_CYCLES     = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [N_REQ-1:0]                       req_valid,
    input  logic [N_REQ-1:0]                       req_wr,
    input  logic [N_REQ*C_S_AXI_ADDR_WIDTH-1:0]    req_addr,
    input  logic [N_REQ*C_S_AXI_DATA_WIDTH-1:0]    req_data,
    output logic [N_REQ-1:0]                       req_ready,
    output logic [N_REQ-1:0]                       rsp_valid,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          rsp_data,
    output logic                                   rsp_err,
    output logic                                   IPIF_bus2ip_resetn,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]          IPIF_bus2ip_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          IPIF_bus2ip_data,
    output logic [N_REG-1:0]                       IPIF_bus2ip_rdce,
    output logic [N_REG-1:0]                       IPIF_bus2ip_wrce,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          IPIF_ip2bus_data,
    input  logic                                   IPIF_ip2bus_rdack,
    input  logic                                   IPIF_ip2bus_wrack
);

    localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
    localparam int unsigned AW    = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned IDX_W = (N_REG > 1) ? $clog2(N_REG) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 2) + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   lat_gnt;
    logic               lat_wr;
    logic               lat_err;
    logic [IDX_W-1:0]   lat_idx;
    logic [CNT_W-1:0]   wait_cnt;

    logic               gnt_found;
    logic [PTR_W-1:0]   gnt_idx;
    int                 cand;
    logic [AW-1:0]      sel_addr;
    logic [DW-1:0]      sel_data;
    logic [AW-1:0]      sel_word;
    logic               sel_err;
    logic [IDX_W-1:0]   sel_idx;
    logic               ack_match;

    // Round-robin pick starting at rr_ptr, plus address decode of the winner
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(rr_ptr) + k) % N_REQ;
            if (!gnt_found && req_valid[PTR_W'(cand)]) begin
                gnt_found = 1'b1;
                gnt_idx   = PTR_W'(cand);
            end
        end
        sel_addr  = req_addr[int'(gnt_idx)*AW +: AW];
        sel_data  = req_data[int'(gnt_idx)*DW +: DW];
        sel_word  = sel_addr >> 2;
        sel_err   = (sel_addr[1:0] != 2'b00) || (sel_word >= AW'(N_REG));
        sel_idx   = IDX_W'(sel_word);
        ack_match = lat_wr ? IPIF_ip2bus_wrack : IPIF_ip2bus_rdack;
    end

    // Transaction FSM; every output is a register updated here
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= S_IDLE;
            rr_ptr             <= '0;
            lat_gnt            <= '0;
            lat_wr             <= 1'b0;
            lat_err            <= 1'b0;
            lat_idx            <= '0;
            wait_cnt           <= '0;
            req_ready          <= '0;
            rsp_valid          <= '0;
            rsp_data           <= '0;
            rsp_err            <= 1'b0;
            IPIF_bus2ip_resetn <= 1'b0;
            IPIF_bus2ip_addr   <= '0;
            IPIF_bus2ip_data   <= '0;
            IPIF_bus2ip_rdce   <= '0;
            IPIF_bus2ip_wrce   <= '0;
        end else begin
            IPIF_bus2ip_resetn <= 1'b1;
            req_ready          <= '0;
            rsp_valid          <= '0;
            IPIF_bus2ip_rdce   <= '0;
            IPIF_bus2ip_wrce   <= '0;
            case (state)
                // RESP also grants, so a request seen during the response cycle starts immediately
                S_IDLE, S_RESP: begin
                    if (gnt_found) begin
                        req_ready[gnt_idx] <= 1'b1;
                        lat_gnt            <= gnt_idx;
                        lat_wr             <= req_wr[gnt_idx];
                        lat_err            <= sel_err;
                        lat_idx            <= sel_idx;
                        IPIF_bus2ip_addr   <= sel_addr;
                        IPIF_bus2ip_data   <= sel_data;
                        rr_ptr             <= PTR_W'((int'(gnt_idx) + 1) % N_REQ);
                        state              <= S_ISSUE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    if (!lat_err) begin
                        if (lat_wr) IPIF_bus2ip_wrce[lat_idx] <= 1'b1;
                        else        IPIF_bus2ip_rdce[lat_idx] <= 1'b1;
                    end
                    state <= S_WAIT;
                end
                // The CE cycle is wait_cnt 0; give up once TIMEOUT_CYCLES silent cycles follow it
                S_WAIT: begin
                    if (lat_err || ack_match || (wait_cnt == CNT_W'(TIMEOUT_CYCLES + 1))) begin
                        rsp_valid[lat_gnt] <= 1'b1;
                        rsp_err            <= lat_err || !ack_match;
                        rsp_data           <= (!lat_err && ack_match && !lat_wr) ? IPIF_ip2bus_data : '0;
                        state              <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
